// File: rtl/raggedstone_spinn_aer_if_multi_debouncer_pkg.sv
// Shared definitions for the multi-channel push-button debouncer:
// per-channel state encoding, level helper and counter sizing.
package raggedstone_spinn_aer_if_multi_debouncer_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } dbnc_state_e;

  // Level a channel rests at when nobody is pressing it.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Counter width wide enough for both the debounce and the hold count.
  function automatic int cnt_width(input int unsigned dbnc_ticks,
                                   input int unsigned hold_ticks);
    int unsigned max_ticks;
    max_ticks = (dbnc_ticks > hold_ticks) ? dbnc_ticks : hold_ticks;
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/raggedstone_spinn_aer_if_multi_debouncer_debounce_ch.sv
// One debouncer channel: 2-flop synchroniser, STABLE/SETTLING FSM with a
// tick-qualified settle counter, and an optional long-press hold counter.
module raggedstone_spinn_aer_if_debounce_ch
  import raggedstone_spinn_aer_if_multi_debouncer_pkg::*;
#(
  parameter int unsigned DBNC_TICKS = 16,
  parameter int unsigned HOLD_TICKS = 0,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int          CNT_W      = cnt_width(16, 0)
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb_i,
  output logic debounced_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam logic             INACTIVE  = inactive_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] DBNC_LOAD = CNT_W'(DBNC_TICKS - 1);

  logic [1:0]       sync_q;
  dbnc_state_e      state_q;
  logic [CNT_W-1:0] dbnc_cnt_q;
  logic             deb_q;
  logic             press_q;
  logic             release_q;

  logic sync_s;
  logic differs;
  logic commit_d;

  assign sync_s   = sync_q[1];
  assign differs  = (sync_s != deb_q);
  assign commit_d = (state_q == ST_SETTLING) && differs && tick &&
                    (dbnc_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{INACTIVE}};
    end else begin
      sync_q <= {sync_q[0], pb_i};
    end
  end

  // Entering SETTLING needs no tick; only the countdown and commit are gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STABLE;
      dbnc_cnt_q <= '0;
      deb_q      <= INACTIVE;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (differs) begin
            state_q    <= ST_SETTLING;
            dbnc_cnt_q <= DBNC_LOAD;
          end
        end
        ST_SETTLING: begin
          if (!differs) begin
            state_q    <= ST_STABLE;
            dbnc_cnt_q <= '0;
          end else if (tick) begin
            if (dbnc_cnt_q == '0) begin
              state_q   <= ST_STABLE;
              deb_q     <= sync_s;
              press_q   <= (sync_s != INACTIVE);
              release_q <= (sync_s == INACTIVE);
            end else begin
              dbnc_cnt_q <= dbnc_cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_STABLE;
          dbnc_cnt_q <= '0;
        end
      endcase
    end
  end

  assign debounced_o = deb_q;
  assign press_o     = press_q;
  assign release_o   = release_q;

  if (HOLD_TICKS > 0) begin : g_hold
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);

    logic [CNT_W-1:0] hold_cnt_q;
    logic             hold_q;
    logic             deb_d;
    logic             active_d;
    logic             press_edge;

    // Looking at the post-commit level lets a same-cycle release veto the pulse.
    always_comb begin
      deb_d      = commit_d ? sync_s : deb_q;
      active_d   = (deb_d != INACTIVE);
      press_edge = commit_d && active_d;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        hold_q <= 1'b0;
        if (!active_d || press_edge) begin
          hold_cnt_q <= '0;
        end else if (tick && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          hold_q     <= ((hold_cnt_q + 1'b1) == HOLD_MAX);
        end
      end
    end

    assign hold_o = hold_q;
  end else begin : g_no_hold
    assign hold_o = 1'b0;
  end

endmodule

// File: rtl/raggedstone_spinn_aer_if_multi_debouncer.sv
// N-channel button/switch debouncer with press, release and long-press pulses;
// all channels share one tick so a single prescaler sets the debounce time.
module raggedstone_spinn_aer_if_multi_debouncer
  import raggedstone_spinn_aer_if_multi_debouncer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DBNC_TICKS = 16,
  parameter int unsigned HOLD_TICKS = 0,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] pb_input,
  output logic [NUM_CH-1:0] pb_debounced,
  output logic [NUM_CH-1:0] pb_press,
  output logic [NUM_CH-1:0] pb_release,
  output logic [NUM_CH-1:0] pb_hold
);

  localparam int CNT_W = cnt_width(DBNC_TICKS, HOLD_TICKS);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    raggedstone_spinn_aer_if_debounce_ch #(
      .DBNC_TICKS (DBNC_TICKS),
      .HOLD_TICKS (HOLD_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .pb_i        (pb_input[ch]),
      .debounced_o (pb_debounced[ch]),
      .press_o     (pb_press[ch]),
      .release_o   (pb_release[ch]),
      .hold_o      (pb_hold[ch])
    );
  end

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_multi_debouncer.sv
// Self-checking bench: reset/press/hold vector table, hand-written corner
// sequences and a randomized run against a run-length reference model.
module tb_raggedstone_spinn_aer_if_multi_debouncer;

  localparam int NUM_CH = 4;
  localparam int DBNC   = 4;
  localparam int HOLD   = 10;
  localparam int HIST   = DBNC + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic [NUM_CH-1:0] pbInput;
  logic [NUM_CH-1:0] pbDebounced;
  logic [NUM_CH-1:0] pbPress;
  logic [NUM_CH-1:0] pbRelease;
  logic [NUM_CH-1:0] pbHold;

  int   checkCount = 0;
  int   failCount  = 0;
  int   cycCnt     = 0;
  bit   gateMode   = 1'b0;
  logic tickAtEdge;

  typedef struct {
    logic              rstV;
    logic [NUM_CH-1:0] inV;
    logic [NUM_CH-1:0] expDeb;
    logic [NUM_CH-1:0] expPress;
    logic [NUM_CH-1:0] expRel;
    logic [NUM_CH-1:0] expHold;
  } vec_t;

  vec_t vecs [21];

  // reference model state
  logic              mdlSamp [NUM_CH][HIST];
  logic [NUM_CH-1:0] mdlDeb;
  logic [NUM_CH-1:0] mdlPress;
  logic [NUM_CH-1:0] mdlRel;
  logic [NUM_CH-1:0] mdlHold;
  int                pressEdge [NUM_CH];
  int                edgeNo;

  raggedstone_spinn_aer_if_multi_debouncer #(
    .NUM_CH     (NUM_CH),
    .DBNC_TICKS (DBNC),
    .HOLD_TICKS (HOLD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .pb_input     (pbInput),
    .pb_debounced (pbDebounced),
    .pb_press     (pbPress),
    .pb_release   (pbRelease),
    .pb_hold      (pbHold)
  );

  always #5 clk = ~clk;

  // one clock edge; outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    tickAtEdge = tick;
    #1;
    cycCnt++;
    tick = gateMode ? ((cycCnt % 4) == 0) : 1'b1;
  endtask

  task automatic applyStimulus(input logic rstV, input logic [NUM_CH-1:0] inV);
    rst     = rstV;
    pbInput = inV;
    step();
  endtask

  task automatic checkVal(input string name, input logic [NUM_CH-1:0] act,
                          input logic [NUM_CH-1:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [NUM_CH-1:0] expDeb,
                             input logic [NUM_CH-1:0] expPress,
                             input logic [NUM_CH-1:0] expRel,
                             input logic [NUM_CH-1:0] expHold);
    checkVal($sformatf("%s.deb", name), pbDebounced, expDeb);
    checkVal($sformatf("%s.press", name), pbPress, expPress);
    checkVal($sformatf("%s.release", name), pbRelease, expRel);
    checkVal($sformatf("%s.hold", name), pbHold, expHold);
  endtask

  task automatic resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b1111);
      checkOutput("reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b0;
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < HIST; j++) mdlSamp[c][j] = 1'b1;
      pressEdge[c] = -1;
    end
    mdlDeb = '1;
    edgeNo = 0;
  endtask

  // A level is accepted once DBNC+1 consecutive samples, ending two edges
  // back (synchroniser delay), all differ from the current debounced level.
  task automatic modelStep(input logic [NUM_CH-1:0] inV);
    bit runOk;
    mdlPress = '0;
    mdlRel   = '0;
    mdlHold  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = HIST - 1; j > 0; j--) mdlSamp[c][j] = mdlSamp[c][j-1];
      mdlSamp[c][0] = inV[c];
      runOk = 1'b1;
      for (int j = 2; j < HIST; j++)
        if (mdlSamp[c][j] == mdlDeb[c]) runOk = 1'b0;
      if (runOk) begin
        mdlDeb[c] = ~mdlDeb[c];
        if (mdlDeb[c] == 1'b0) begin
          mdlPress[c]  = 1'b1;
          pressEdge[c] = edgeNo;
        end else begin
          mdlRel[c]    = 1'b1;
          pressEdge[c] = -1;
        end
      end else if (mdlDeb[c] == 1'b0 && pressEdge[c] >= 0 &&
                   (edgeNo - pressEdge[c]) == HOLD) begin
        mdlHold[c] = 1'b1;
      end
    end
    edgeNo++;
  endtask

  initial begin
    logic [NUM_CH-1:0] expD;
    logic [NUM_CH-1:0] expP;
    logic [NUM_CH-1:0] nextIn;
    int                tcount;
    bit                justHit;
    int                flipDiv;

    rst     = 1'b1;
    tick    = 1'b1;
    pbInput = 4'b0000;

    // reset, post-reset press of all channels, release of ch0, hold of ch1-3
    vecs[0]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 3; i <= 8; i++)
      vecs[i] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 11; i <= 16; i++)
      vecs[i] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[17] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    vecs[18] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[19] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1110};
    vecs[20] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rstV, vecs[i].inV);
      checkOutput($sformatf("vec%0d", i), vecs[i].expDeb, vecs[i].expPress,
                  vecs[i].expRel, vecs[i].expHold);
    end

    // clean press on ch0
    resetDut();
    for (int e = 0; e <= 8; e++) begin
      applyStimulus(1'b0, 4'b1110);
      checkOutput($sformatf("clean_e%0d", e), (e >= 6) ? 4'b1110 : 4'b1111,
                  (e == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
    end

    // bounce on ch1: edges 0..1 low, 2..3 high, low from edge 4 on
    resetDut();
    for (int e = 0; e <= 12; e++) begin
      applyStimulus(1'b0, (e == 2 || e == 3) ? 4'b1111 : 4'b1101);
      checkOutput($sformatf("bounce_e%0d", e), (e - 4 >= 6) ? 4'b1101 : 4'b1111,
                  (e - 4 == 6) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000);
    end

    // 3-clock glitch on ch2 must be swallowed
    resetDut();
    for (int e = 0; e <= 14; e++) begin
      applyStimulus(1'b0, (e < 3) ? 4'b1011 : 4'b1111);
      checkOutput($sformatf("glitch_e%0d", e), 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end

    // long press on ch3: low for edges 0..29
    resetDut();
    for (int e = 0; e <= 40; e++) begin
      applyStimulus(1'b0, (e >= 30) ? 4'b1111 : 4'b0111);
      checkOutput($sformatf("long_e%0d", e),
                  (e >= 6 && e < 36) ? 4'b0111 : 4'b1111,
                  (e == 6) ? 4'b1000 : 4'b0000,
                  (e == 36) ? 4'b1000 : 4'b0000,
                  (e == 16) ? 4'b1000 : 4'b0000);
    end
    // short press on ch3: low for edges 0..7, active 8 clocks, no hold
    for (int e = 0; e <= 20; e++) begin
      applyStimulus(1'b0, (e >= 8) ? 4'b1111 : 4'b0111);
      checkOutput($sformatf("short_e%0d", e),
                  (e >= 6 && e < 14) ? 4'b0111 : 4'b1111,
                  (e == 6) ? 4'b1000 : 4'b0000,
                  (e == 14) ? 4'b1000 : 4'b0000, 4'b0000);
    end

    // tick every 4th clock: commit on the 4th tick edge from edge 3 onward
    gateMode = 1'b1;
    resetDut();
    tcount = 0;
    for (int e = 0; e <= 40; e++) begin
      applyStimulus(1'b0, 4'b1110);
      justHit = 1'b0;
      if (e >= 3 && tickAtEdge) begin
        tcount++;
        justHit = (tcount == 4);
      end
      expD = (tcount >= 4) ? 4'b1110 : 4'b1111;
      expP = justHit ? 4'b0001 : 4'b0000;
      checkOutput($sformatf("tick_e%0d", e), expD, expP, 4'b0000, 4'b0000);
    end

    // reset while ch0 is settling discards the pending press
    resetDut();
    for (int e = 0; e <= 3; e++) begin
      applyStimulus(1'b0, 4'b1110);
      checkOutput($sformatf("midrst_pre%0d", e), 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int e = 0; e < 2; e++) begin
      applyStimulus(1'b1, 4'b1111);
      checkOutput($sformatf("midrst_rst%0d", e), 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int e = 0; e < 20; e++) begin
      applyStimulus(1'b0, 4'b1111);
      checkOutput($sformatf("midrst_post%0d", e), 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end

    // randomized run against the reference model, tick tied high
    gateMode = 1'b0;
    tick     = 1'b1;
    resetDut();
    modelReset();
    nextIn = 4'b1111;
    for (int n = 0; n < 600; n++) begin
      flipDiv = (n < 300) ? 5 : 20;
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(flipDiv - 1, 0) == 0) nextIn[c] = ~nextIn[c];
      applyStimulus(1'b0, nextIn);
      modelStep(nextIn);
      checkOutput($sformatf("rand%0d", n), mdlDeb, mdlPress, mdlRel, mdlHold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
